// File: rtl/trace_player_if.sv
// Request/response channel between the trace player and the cache under test.
//   req_valid / req_ready / req_addr : one memory reference per handshake
//   rsp_valid / rsp_hit              : single-cycle hit/miss reply
// Modports:
//   master - trace player side (drives requests, receives responses)
//   slave  - cache side (accepts requests, returns responses)
interface trace_player_if #(
  parameter int REF_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [REF_W-1:0] req_addr;
  logic             rsp_valid;
  logic             rsp_hit;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_hit
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_hit
  );
endinterface

// File: rtl/trace_player.sv
// Trace player: replays trace ROM entries 0..TRACE_LEN-1 into a cache model,
// one outstanding reference at a time, and counts hits, misses and responses.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start             - begin a replay (honoured only when idle or done)
//   trace_addr        - ROM address (driven straight from the index register)
//   trace_ref         - ROM data, valid in the same cycle as trace_addr
//   bus (master)      - req_valid/req_ready/req_addr and rsp_valid/rsp_hit
//   busy, done        - replay in progress / replay finished (held)
//   hit_count, miss_count, ref_count - saturating statistics for this replay
module trace_player #(
  parameter int ADDR_W    = 16,
  parameter int REF_W     = 32,
  parameter int TRACE_LEN = 6,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] trace_addr,
  input  logic [REF_W-1:0]  trace_ref,
  trace_player_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  ref_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_RSP,
    DONE
  } state_t;

  localparam bit              LEN_ZERO = (TRACE_LEN == 0);
  // One bit wider than the index so TRACE_LEN == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LEN_V    = (ADDR_W+1)'(TRACE_LEN);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  index;
  logic               req_valid_r;
  logic [REF_W-1:0]   req_addr_r;
  logic               last;

  logic               clr_stats;
  logic               load_req;
  logic               accept;
  logic               count_rsp;
  logic               adv_index;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign trace_addr    = index;
  assign bus.req_valid = req_valid_r;
  assign bus.req_addr  = req_addr_r;

  assign last = (({1'b0, index} + (ADDR_W+1)'(1)) == LEN_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_stats = 1'b0;
    load_req  = 1'b0;
    accept    = 1'b0;
    count_rsp = 1'b0;
    adv_index = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          clr_stats = 1'b1;
          state_nxt = LEN_ZERO ? DONE : FETCH;
        end
      end
      FETCH: begin
        load_req  = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (req_valid_r && bus.req_ready) begin
          accept    = 1'b1;
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.rsp_valid) begin
          count_rsp = 1'b1;
          // The index is left on the final entry so the ROM address never
          // runs past the end of the trace while done.
          if (last) begin
            state_nxt = DONE;
          end else begin
            adv_index = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index       <= '0;
      req_valid_r <= 1'b0;
      req_addr_r  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
      ref_count   <= '0;
    end else begin
      busy <= (state_nxt == FETCH) || (state_nxt == ISSUE) || (state_nxt == WAIT_RSP);
      done <= (state_nxt == DONE);

      if (clr_stats) begin
        index      <= '0;
        hit_count  <= '0;
        miss_count <= '0;
        ref_count  <= '0;
      end

      if (load_req) begin
        req_addr_r  <= trace_ref;
        req_valid_r <= 1'b1;
      end

      if (accept) begin
        req_valid_r <= 1'b0;
      end

      if (count_rsp) begin
        ref_count <= sat_inc(ref_count);
        if (bus.rsp_hit) begin
          hit_count <= sat_inc(hit_count);
        end else begin
          miss_count <= sat_inc(miss_count);
        end
      end

      if (adv_index) begin
        index <= index + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trace_player.sv
module tb_trace_player;
  localparam int ADDR_W    = 16;
  localparam int REF_W     = 32;
  localparam int TRACE_LEN = 6;
  localparam int CNT_W     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (TRACE_LEN = 6)
  logic [ADDR_W-1:0] trace_addr;
  logic [REF_W-1:0]  trace_ref;
  logic              busy, done;
  logic [CNT_W-1:0]  hit_count, miss_count, ref_count;
  trace_player_if #(.REF_W(REF_W)) bus ();

  trace_player #(.ADDR_W(ADDR_W), .REF_W(REF_W), .TRACE_LEN(TRACE_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .trace_addr(trace_addr), .trace_ref(trace_ref),
    .bus(bus),
    .busy(busy), .done(done),
    .hit_count(hit_count), .miss_count(miss_count), .ref_count(ref_count)
  );

  // Empty-trace DUT (TRACE_LEN = 0)
  logic              start0 = 1'b0;
  logic [ADDR_W-1:0] trace_addr0;
  logic              busy0, done0;
  logic [CNT_W-1:0]  hit0, miss0, ref0;
  trace_player_if #(.REF_W(REF_W)) bus0 ();

  trace_player #(.ADDR_W(ADDR_W), .REF_W(REF_W), .TRACE_LEN(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .trace_addr(trace_addr0), .trace_ref(32'h0),
    .bus(bus0),
    .busy(busy0), .done(done0),
    .hit_count(hit0), .miss_count(miss0), .ref_count(ref0)
  );

  // Trace ROM contents; out-of-range reads return a marker value.
  function automatic logic [REF_W-1:0] rom_at(input int i);
    case (i)
      0, 1, 5: return 32'h0000_0000;
      2, 3, 4: return 32'h5000_0000;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign trace_ref = rom_at(int'(trace_addr));

  // Cache model and stimulus configuration (config written only by the main process)
  int stall_entry = -1;
  int stall_cfg   = 0;
  bit spur        = 1'b0;

  bit               pending = 1'b0;
  bit               pend_hit = 1'b0;
  bit               in_wait = 1'b0;
  logic [REF_W-1:0] seen [0:7];
  int               seen_n = 0;
  int               stall_cnt = 0;
  int               issued = 0;
  logic [REF_W-1:0] req_log [0:63];
  int               log_n = 0;
  int               stall_obs = 0;
  int               stall_bad = 0;
  bit               zero_rv_seen = 1'b0;

  always @(negedge clk) begin
    bit hit_now;
    bus.rsp_valid = 1'b0;
    bus.rsp_hit   = 1'b0;
    in_wait       = 1'b0;
    if (bus0.req_valid === 1'b1) zero_rv_seen = 1'b1;
    if (rst) begin
      pending       = 1'b0;
      bus.req_ready = 1'b1;
    end else begin
      if (!busy) begin
        seen_n    = 0;
        stall_cnt = stall_cfg;
      end
      if (pending) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_hit   = pend_hit;
        pending       = 1'b0;
        in_wait       = 1'b1;
      end else if (spur && (busy || done)) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_hit   = 1'b1;
      end
      if (bus.req_valid && stall_cnt > 0 && int'(trace_addr) == stall_entry) begin
        bus.req_ready = 1'b0;
        stall_cnt--;
        stall_obs++;
        if (bus.req_addr !== rom_at(stall_entry)) stall_bad++;
      end else begin
        bus.req_ready = 1'b1;
      end
      if (bus.req_valid && bus.req_ready) begin
        issued++;
        if (log_n < 64) begin
          req_log[log_n] = bus.req_addr;
          log_n++;
        end
        hit_now = 1'b0;
        for (int k = 0; k < seen_n; k++) if (seen[k] == bus.req_addr) hit_now = 1'b1;
        if (!hit_now && seen_n < 8) begin
          seen[seen_n] = bus.req_addr;
          seen_n++;
        end
        pending  = 1'b1;
        pend_hit = hit_now;
      end
    end
  end

  initial begin
    bus0.req_ready = 1'b1;
    bus0.rsp_valid = 1'b0;
    bus0.rsp_hit   = 1'b0;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int stall_entry;
    int stall_cycles;
    bit spur;
    int extra_start;
    int exp_cycles;
    int exp_hit;
    int exp_miss;
    int exp_ref;
  } vec_t;

  vec_t vecs [0:4];

  task automatic run_row(input int r);
    int cyc;
    int b_issued, b_log, b_obs, b_bad;
    stall_entry = vecs[r].stall_entry;
    stall_cfg   = vecs[r].stall_cycles;
    spur        = vecs[r].spur;
    b_issued = issued; b_log = log_n; b_obs = stall_obs; b_bad = stall_bad;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk($sformatf("r%0d_busy_start", r), 32'(busy), 32'd1);
    chk($sformatf("r%0d_done_clr", r), 32'(done), 32'd0);
    chk($sformatf("r%0d_ref_clr", r), 32'(ref_count), 32'd0);
    cyc = 0;
    while (!done && cyc < 200) begin
      start = (cyc == vecs[r].extra_start);
      tick;
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("r%0d_cycles", r), 32'(cyc), 32'(vecs[r].exp_cycles));
    chk($sformatf("r%0d_hit", r), 32'(hit_count), 32'(vecs[r].exp_hit));
    chk($sformatf("r%0d_miss", r), 32'(miss_count), 32'(vecs[r].exp_miss));
    chk($sformatf("r%0d_ref", r), 32'(ref_count), 32'(vecs[r].exp_ref));
    chk($sformatf("r%0d_busy_end", r), 32'(busy), 32'd0);
    chk($sformatf("r%0d_issued", r), 32'(issued - b_issued), 32'(vecs[r].exp_ref));
    for (int i = 0; i < TRACE_LEN; i++)
      chk($sformatf("r%0d_req_addr%0d", r, i), req_log[(b_log + i) % 64], rom_at(i));
    chk($sformatf("r%0d_stall_cycles", r), 32'(stall_obs - b_obs), 32'(vecs[r].stall_cycles));
    chk($sformatf("r%0d_stall_stable", r), 32'(stall_bad - b_bad), 32'd0);
    repeat (3) tick;
    chk($sformatf("r%0d_hit_frozen", r), 32'(hit_count), 32'(vecs[r].exp_hit));
    chk($sformatf("r%0d_miss_frozen", r), 32'(miss_count), 32'(vecs[r].exp_miss));
    chk($sformatf("r%0d_ref_frozen", r), 32'(ref_count), 32'(vecs[r].exp_ref));
    chk($sformatf("r%0d_done_held", r), 32'(done), 32'd1);
    spur        = 1'b0;
    stall_entry = -1;
    stall_cfg   = 0;
  endtask

  initial begin
    int cyc;
    // stall_entry, stall_cycles, spur, extra_start, cycles, hit, miss, ref
    vecs[0] = '{-1, 0, 1'b0, -1, 18, 4, 2, 6};  // basic replay from IDLE
    vecs[1] = '{ 2, 5, 1'b0, -1, 23, 4, 2, 6};  // backpressure on entry 2
    vecs[2] = '{-1, 0, 1'b1, -1, 18, 4, 2, 6};  // spurious responses
    vecs[3] = '{-1, 0, 1'b0,  7, 18, 4, 2, 6};  // start while busy is ignored
    vecs[4] = '{-1, 0, 1'b0, -1, 18, 4, 2, 6};  // restart from DONE

    rst = 1'b1;
    repeat (3) tick;
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_req_addr", bus.req_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_counts", 32'({hit_count, miss_count} | 32'(ref_count)), 32'd0);
    chk("rst_trace_addr", 32'(trace_addr), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    rst = 1'b0;
    tick;

    // Empty trace: done the cycle after start, nothing issued.
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("len0_done", 32'(done0), 32'd1);
    chk("len0_busy", 32'(busy0), 32'd0);
    chk("len0_counts", 32'({hit0, miss0} | 32'(ref0)), 32'd0);
    tick;
    chk("len0_done_held", 32'(done0), 32'd1);

    for (int r = 0; r < 5; r++) run_row(r);

    // Reset during WAIT_RSP of entry 3, coinciding with its response.
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!(in_wait && trace_addr == ADDR_W'(3)) && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("mid_wait_found", 32'(in_wait && trace_addr == ADDR_W'(3)), 32'd1);
    chk("mid_ref_before", 32'(ref_count), 32'd3);
    rst = 1'b1;
    tick;
    chk("mid_req_valid", 32'(bus.req_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_hit", 32'(hit_count), 32'd0);
    chk("mid_miss", 32'(miss_count), 32'd0);
    chk("mid_ref", 32'(ref_count), 32'd0);
    chk("mid_trace_addr", 32'(trace_addr), 32'd0);
    rst = 1'b0;
    repeat (2) tick;
    chk("mid_idle_busy", 32'(busy), 32'd0);
    run_row(0);

    chk("len0_no_req_valid", 32'(zero_rv_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
